// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER trap/return controller:
// next-PC select codes, machine CSR addresses, mstatus bit positions,
// and the trap FSM state type.
package otter_pkg;

   // Next-PC mux select codes
   typedef enum logic [2:0] {
      PC_SEL_PC4    = 3'd0,
      PC_SEL_JALR   = 3'd1,
      PC_SEL_BRANCH = 3'd2,
      PC_SEL_JAL    = 3'd3,
      PC_SEL_MTVEC  = 3'd4,
      PC_SEL_MEPC   = 3'd5
   } pc_sel_t;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // mcause value for a machine external interrupt
   localparam logic [31:0] MCAUSE_MEXT_IRQ = 32'h8000_000B;

   // Trap FSM states
   typedef enum logic [1:0] {
      TRAP_IDLE = 2'd0,
      TRAP_TRAP = 2'd1,
      TRAP_RET  = 2'd2
   } trap_state_t;

endpackage

// File: rtl/otter_trap_ctrl_if.sv
// Bus between the control unit (master) and the trap controller (slave):
// instruction-boundary info, CSR access and the next-PC redirect outputs.
interface otter_trap_ctrl_if;
   import otter_pkg::*;

   logic          INSTR_DONE;
   logic [31:0]   NEXT_PC;
   logic          MRET_EXEC;
   logic          CSR_WE;
   logic [11:0]   CSR_ADDR;
   logic [31:0]   CSR_WD;
   logic [31:0]   CSR_RD;
   logic [31:0]   MTVEC;
   logic [31:0]   MEPC;
   pc_sel_t       PC_SEL;
   logic          REDIRECT;
   logic          TRAP_TAKEN;

   modport master (
      output INSTR_DONE, NEXT_PC, MRET_EXEC, CSR_WE, CSR_ADDR, CSR_WD,
      input  CSR_RD, MTVEC, MEPC, PC_SEL, REDIRECT, TRAP_TAKEN
   );

   modport slave (
      input  INSTR_DONE, NEXT_PC, MRET_EXEC, CSR_WE, CSR_ADDR, CSR_WD,
      output CSR_RD, MTVEC, MEPC, PC_SEL, REDIRECT, TRAP_TAKEN
   );

endinterface

// File: rtl/otter_sync_flop.sv
// N-stage flop chain that brings an asynchronous level into the clk domain.
// Synchronous active-high reset clears every stage.
module otter_sync_flop #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   // Shift the input one stage further down the chain each cycle
   always_comb begin
      sync_d = {sync_q[N-2:0], d};
   end

   // Chain registers
   always_ff @(posedge clk) begin
      if (srst) sync_q <= '0;
      else      sync_q <= sync_d;
   end

   assign q = sync_q[N-1];

endmodule

// File: rtl/otter_trap_ctrl.sv
// Machine-mode trap entry / MRET controller for the OTTER core.
// Owns mtvec, mepc and mstatus (MIE/MPIE), synchronises INTR and issues a
// one-cycle registered redirect to the next-PC mux.
// Optional: define OTTER_MCAUSE_EN to add the mcause CSR (0x342).
module otter_trap_ctrl
   import otter_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           INTR,
   otter_trap_ctrl_if.slave bus
);

   logic          intr_s;
   logic          irq_ok;
   logic          boundary;
   logic          csr_wr;

   trap_state_t   state_q,      state_d;
   logic [31:0]   mtvec_q,      mtvec_d;
   logic [31:0]   mepc_q,       mepc_d;
   logic          mie_q,        mie_d;
   logic          mpie_q,       mpie_d;
   logic          redirect_q,   redirect_d;
   logic          trap_taken_q, trap_taken_d;
   pc_sel_t       pc_sel_q,     pc_sel_d;
`ifdef OTTER_MCAUSE_EN
   logic [31:0]   mcause_q,     mcause_d;
`endif

   logic [31:0]   mstatus_rd;
   logic [31:0]   csr_rd;
   logic          unused_bits;

   otter_sync_flop #(.N(SYNC_STAGES)) u_intr_sync (
      .clk  (CLK),
      .srst (RST),
      .d    (INTR),
      .q    (intr_s)
   );

   // Only the low bits the CSRs never store are dropped here
   assign unused_bits = ^{bus.NEXT_PC[1:0], bus.CSR_WD[1:0]};

   assign irq_ok   = intr_s & mie_q;
   // Boundaries seen during TRAP/RET are ignored entirely
   assign boundary = bus.INSTR_DONE & (state_q == TRAP_IDLE);
   assign csr_wr   = bus.CSR_WE & boundary;

   assign mstatus_rd = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};

   // Next-state: CSR writes first, then trap/MRET updates override mstatus/mepc
   always_comb begin
      state_d      = TRAP_IDLE;
      mtvec_d      = mtvec_q;
      mepc_d       = mepc_q;
      mie_d        = mie_q;
      mpie_d       = mpie_q;
      redirect_d   = 1'b0;
      trap_taken_d = 1'b0;
      pc_sel_d     = PC_SEL_PC4;
`ifdef OTTER_MCAUSE_EN
      mcause_d     = mcause_q;
`endif

      if (csr_wr) begin
         case (bus.CSR_ADDR)
            CSR_MTVEC:   mtvec_d = {bus.CSR_WD[31:2], 2'b00};
            CSR_MEPC:    mepc_d  = {bus.CSR_WD[31:2], 2'b00};
            CSR_MSTATUS: begin
               mie_d  = bus.CSR_WD[MSTATUS_MIE];
               mpie_d = bus.CSR_WD[MSTATUS_MPIE];
            end
`ifdef OTTER_MCAUSE_EN
            CSR_MCAUSE:  mcause_d = bus.CSR_WD;
`endif
            default: ;
         endcase
      end

      case (state_q)
         TRAP_IDLE: begin
            if (boundary) begin
               if (bus.MRET_EXEC) begin
                  // MRET beats a pending interrupt; it is re-checked next boundary
                  mie_d      = mpie_q;
                  mpie_d     = 1'b1;
                  state_d    = TRAP_RET;
                  redirect_d = 1'b1;
                  pc_sel_d   = PC_SEL_MEPC;
               end else if (irq_ok) begin
                  mepc_d       = {bus.NEXT_PC[31:2], 2'b00};
                  mpie_d       = mie_q;
                  mie_d        = 1'b0;
                  state_d      = TRAP_TRAP;
                  redirect_d   = 1'b1;
                  trap_taken_d = 1'b1;
                  pc_sel_d     = PC_SEL_MTVEC;
`ifdef OTTER_MCAUSE_EN
                  mcause_d     = MCAUSE_MEXT_IRQ;
`endif
               end
            end
         end
         default: state_d = TRAP_IDLE;
      endcase
   end

   // FSM, CSR and registered redirect outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= TRAP_IDLE;
         mtvec_q      <= MTVEC_RST;
         mepc_q       <= 32'd0;
         mie_q        <= 1'b0;
         mpie_q       <= 1'b0;
         redirect_q   <= 1'b0;
         trap_taken_q <= 1'b0;
         pc_sel_q     <= PC_SEL_PC4;
`ifdef OTTER_MCAUSE_EN
         mcause_q     <= 32'd0;
`endif
      end else begin
         state_q      <= state_d;
         mtvec_q      <= mtvec_d;
         mepc_q       <= mepc_d;
         mie_q        <= mie_d;
         mpie_q       <= mpie_d;
         redirect_q   <= redirect_d;
         trap_taken_q <= trap_taken_d;
         pc_sel_q     <= pc_sel_d;
`ifdef OTTER_MCAUSE_EN
         mcause_q     <= mcause_d;
`endif
      end
   end

   // CSR read decode; shows current (pre-write) register contents
   always_comb begin
      csr_rd = 32'd0;
      case (bus.CSR_ADDR)
         CSR_MSTATUS: csr_rd = mstatus_rd;
         CSR_MTVEC:   csr_rd = mtvec_q;
         CSR_MEPC:    csr_rd = mepc_q;
`ifdef OTTER_MCAUSE_EN
         CSR_MCAUSE:  csr_rd = mcause_q;
`endif
         default:     csr_rd = 32'd0;
      endcase
   end

   assign bus.CSR_RD     = csr_rd;
   assign bus.MTVEC      = mtvec_q;
   assign bus.MEPC       = mepc_q;
   assign bus.PC_SEL     = pc_sel_q;
   assign bus.REDIRECT   = redirect_q;
   assign bus.TRAP_TAKEN = trap_taken_q;

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Scoreboard bench for otter_trap_ctrl: the stimulus pushes each expected
// redirect into a queue and a monitor pops/compares whenever REDIRECT is high.
// CSR read-backs are compared directly by the stimulus process.
`timescale 1ns/1ps
module tb_otter_trap_ctrl;
   import otter_pkg::*;

   typedef struct {
      logic [2:0]  sel;
      logic        trap;
      logic [31:0] mtvec;
      logic [31:0] mepc;
   } exp_t;

   logic clk;
   logic rst;
   logic intr;
   int   tests;
   int   fails;
   int   redirect_cnt;
   exp_t exp_q[$];

   otter_trap_ctrl_if bus();

   otter_trap_ctrl #(.SYNC_STAGES(2), .MTVEC_RST(32'h0000_0000)) dut (
      .CLK  (clk),
      .RST  (rst),
      .INTR (intr),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%08h", name, act);
      end
   endtask

   // Monitor: every redirect cycle must match the oldest expected entry
   always @(negedge clk) begin
      if (bus.REDIRECT === 1'b1) begin
         redirect_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_redirect: got PC_SEL=%0d, expected no redirect", bus.PC_SEL);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("[TB] redirect PC_SEL=%0d TRAP_TAKEN=%0b MTVEC=0x%08h MEPC=0x%08h",
                     bus.PC_SEL, bus.TRAP_TAKEN, bus.MTVEC, bus.MEPC);
            check("redir_pc_sel", {29'd0, bus.PC_SEL}, {29'd0, e.sel});
            check("redir_trap_taken", {31'd0, bus.TRAP_TAKEN}, {31'd0, e.trap});
            check("redir_mtvec", bus.MTVEC, e.mtvec);
            check("redir_mepc", bus.MEPC, e.mepc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [2:0] sel, input logic trap,
                           input logic [31:0] mtvec, input logic [31:0] mepc);
      exp_t e;
      e.sel = sel; e.trap = trap; e.mtvec = mtvec; e.mepc = mepc;
      exp_q.push_back(e);
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
      bus.CSR_ADDR   = addr;
      bus.CSR_WD     = data;
      bus.CSR_WE     = 1'b1;
      bus.INSTR_DONE = 1'b1;
      tick(1);
      bus.CSR_WE     = 1'b0;
      bus.INSTR_DONE = 1'b0;
      tick(1);
   endtask

   task automatic csr_read(input string name, input logic [11:0] addr, input logic [31:0] exp);
      bus.CSR_ADDR = addr;
      #1;
      check(name, bus.CSR_RD, exp);
   endtask

   // One instruction boundary, then one cycle for any TRAP/RET to play out
   task automatic boundary(input logic [31:0] pc, input logic mret);
      bus.NEXT_PC    = pc;
      bus.MRET_EXEC  = mret;
      bus.INSTR_DONE = 1'b1;
      tick(1);
      bus.INSTR_DONE = 1'b0;
      bus.MRET_EXEC  = 1'b0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0;
      tests = 0; fails = 0; redirect_cnt = 0;
      rst = 1'b1; intr = 1'b0;
      bus.INSTR_DONE = 1'b0; bus.NEXT_PC = 32'd0; bus.MRET_EXEC = 1'b0;
      bus.CSR_WE = 1'b0; bus.CSR_ADDR = 12'd0; bus.CSR_WD = 32'd0;

      // 1. Reset then read
      tick(2);
      rst = 1'b0;
      tick(1);
      csr_read("rst_mstatus", CSR_MSTATUS, 32'h0);
      csr_read("rst_mtvec", CSR_MTVEC, 32'h0);
      csr_read("rst_mepc", CSR_MEPC, 32'h0);
      check("rst_redirect", {31'd0, bus.REDIRECT}, 32'd0);
      check("rst_pc_sel", {29'd0, bus.PC_SEL}, 32'd0);

      // 2. Interrupt with MIE=1
      csr_write(CSR_MTVEC, 32'h0000_0107);
      csr_read("mtvec_align", CSR_MTVEC, 32'h0000_0104);
      csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
      csr_read("mstatus_mask", CSR_MSTATUS, 32'h0000_0088);
      csr_write(CSR_MSTATUS, 32'h0000_0008);
      csr_read("mstatus_mie", CSR_MSTATUS, 32'h0000_0008);
      csr_write(12'h123, 32'hDEAD_BEEF);
      csr_read("unknown_csr", 12'h123, 32'h0);
      intr = 1'b1;
      tick(3);
      push_exp(3'd4, 1'b1, 32'h0000_0104, 32'h0000_2008);
      boundary(32'h0000_200B, 1'b0);
      csr_read("trap_mepc", CSR_MEPC, 32'h0000_2008);
      csr_read("trap_mstatus", CSR_MSTATUS, 32'h0000_0080);
`ifdef OTTER_MCAUSE_EN
      csr_read("trap_mcause", CSR_MCAUSE, 32'h8000_000B);
`else
      csr_read("trap_mcause", CSR_MCAUSE, 32'h0);
`endif

      // 3. MRET (interrupt dropped first so MIE=1 does not re-trap)
      intr = 1'b0;
      tick(3);
      push_exp(3'd5, 1'b0, 32'h0000_0104, 32'h0000_2008);
      boundary(32'h0000_0000, 1'b1);
      csr_read("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);

      // 4. INTR high with MIE=0: no traps until MIE is set
      csr_write(CSR_MSTATUS, 32'h0);
      intr = 1'b1;
      tick(3);
      cnt0 = redirect_cnt;
      for (int i = 0; i < 10; i++) boundary(32'h0000_1000 + 32'(i * 4), 1'b0);
      check("mie0_no_redirect", 32'(redirect_cnt), 32'(cnt0));
      csr_write(CSR_MSTATUS, 32'h0000_0008);  // same boundary must not trap
      check("mie_set_no_same_trap", 32'(redirect_cnt), 32'(cnt0));
      push_exp(3'd4, 1'b1, 32'h0000_0104, 32'h0000_3000);
      boundary(32'h0000_3000, 1'b0);
      csr_read("t4_mstatus", CSR_MSTATUS, 32'h0000_0080);

      // 5. Simultaneous MRET and irq_ok with MPIE=1
      csr_write(CSR_MSTATUS, 32'h0000_0088);
      push_exp(3'd5, 1'b0, 32'h0000_0104, 32'h0000_3000);
      boundary(32'h0000_3100, 1'b1);
      csr_read("t5_mstatus", CSR_MSTATUS, 32'h0000_0088);
      push_exp(3'd4, 1'b1, 32'h0000_0104, 32'h0000_4004);
      boundary(32'h0000_4004, 1'b0);
      csr_read("t5_mepc", CSR_MEPC, 32'h0000_4004);

      // 6. Reset asserted during the TRAP cycle
      csr_write(CSR_MSTATUS, 32'h0000_0008);
      push_exp(3'd4, 1'b1, 32'h0000_0104, 32'h0000_5000);
      bus.NEXT_PC = 32'h0000_5000;
      bus.INSTR_DONE = 1'b1;
      tick(1);
      bus.INSTR_DONE = 1'b0;
      check("t6_in_trap", {31'd0, bus.REDIRECT}, 32'd1);
      rst = 1'b1;
      tick(1);
      check("t6_redirect", {31'd0, bus.REDIRECT}, 32'd0);
      check("t6_trap_taken", {31'd0, bus.TRAP_TAKEN}, 32'd0);
      check("t6_pc_sel", {29'd0, bus.PC_SEL}, 32'd0);
      rst = 1'b0;
      tick(1);
      check("t6_redirect_after", {31'd0, bus.REDIRECT}, 32'd0);
      csr_read("t6_mstatus", CSR_MSTATUS, 32'h0);
      csr_read("t6_mtvec", CSR_MTVEC, 32'h0);
      csr_read("t6_mepc", CSR_MEPC, 32'h0);
      csr_read("t6_mcause", CSR_MCAUSE, 32'h0);
      csr_write(CSR_MCAUSE, 32'h0000_0055);
`ifdef OTTER_MCAUSE_EN
      csr_read("mcause_wr", CSR_MCAUSE, 32'h0000_0055);
`else
      csr_read("mcause_wr", CSR_MCAUSE, 32'h0);
`endif
      // INTR still high but MIE cleared by reset: no trap
      cnt0 = redirect_cnt;
      boundary(32'h0000_6000, 1'b0);
      check("post_rst_no_trap", 32'(redirect_cnt), 32'(cnt0));

      tick(2);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
